// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 key-code display: segment codes,
// default refresh divider and the digit index type.
package kbd_pkg;

    localparam logic [6:0] SEG_BLANK           = 7'h7F;
    localparam int         REFRESH_DIV_DEFAULT = 100000;

    typedef logic [1:0] digit_idx_t;

    // Active-low {g,f,e,d,c,b,a}; entry 15 (F) first, entry 0 last.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/key_display_mux_if.sv
// Bundle of the PS/2 key input and the 7-segment display outputs.
interface key_display_mux_if;
    import kbd_pkg::*;

    logic [7:0] keyPressed;
    logic       kpSignal;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       newKey;
    logic [7:0] curCode;

    modport master (
        output keyPressed, kpSignal,
        input  seg, an, dp, newKey, curCode
    );

    modport slave (
        input  keyPressed, kpSignal,
        output seg, an, dp, newKey, curCode
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module hex_to_seg7
    import kbd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/key_display_mux.sv
// Captures PS/2 scan codes into a 2-deep history and scans them as hex
// across a 4-digit multiplexed 7-segment display.
module key_display_mux
    import kbd_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
    parameter bit BLANK_EMPTY = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    key_display_mux_if.slave bus
);

    localparam int DIV_W = $clog2(REFRESH_DIV);

    logic             s1_q, s2_q, s3_q;
    logic             new_key_q;
    logic [7:0]       cur_q, prev_q;
    logic             vcur_q, vprev_q;
    logic [DIV_W-1:0] div_q;
    digit_idx_t       idx_q;
    logic [6:0]       seg_q;
    logic [3:0]       an_q;

    logic       cap;
    logic       div_wrap;
    logic [3:0] nib_d;
    logic       valid_d;
    logic [6:0] hex_seg;
    logic [6:0] seg_d;
    logic [3:0] an_d;

    // Rising edge of the synchronized strobe; s3 is only an edge-detect copy.
    assign cap      = s2_q & ~s3_q;
    assign div_wrap = (div_q == DIV_W'(REFRESH_DIV - 1));

    always_comb begin
        nib_d   = 4'h0;
        valid_d = 1'b0;
        case (idx_q)
            2'd0: begin nib_d = cur_q[3:0];  valid_d = vcur_q;  end
            2'd1: begin nib_d = cur_q[7:4];  valid_d = vcur_q;  end
            2'd2: begin nib_d = prev_q[3:0]; valid_d = vprev_q; end
            2'd3: begin nib_d = prev_q[7:4]; valid_d = vprev_q; end
            default: ;
        endcase
    end

    hex_to_seg7 u_hex (
        .nib_i (nib_d),
        .seg_o (hex_seg)
    );

    assign seg_d = (BLANK_EMPTY && !valid_d) ? SEG_BLANK : hex_seg;
    assign an_d  = ~(4'b0001 << idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            new_key_q <= 1'b0;
            cur_q     <= 8'h00;
            prev_q    <= 8'h00;
            vcur_q    <= 1'b0;
            vprev_q   <= 1'b0;
            div_q     <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= 4'hF;
        end else begin
            s1_q      <= bus.kpSignal;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            new_key_q <= cap;
            if (cap) begin
                prev_q  <= cur_q;
                vprev_q <= vcur_q;
                cur_q   <= bus.keyPressed;
                vcur_q  <= 1'b1;
            end
            if (div_wrap) begin
                div_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.dp      = 1'b1;
    assign bus.newKey  = new_key_q;
    assign bus.curCode = cur_q;

endmodule

// File: doc/key_display_mux.md
Name: key_display_mux

Overview:
- Consumes the PS/2 receiver's `keyPressed[7:0]` and `kpSignal` strobe, which come from the PS2Clk domain.
- Brings the strobe into the system clock domain and keeps a 2-entry history of received codes.
- Time-multiplexes both codes as hex onto the 4-digit active-low 7-segment display.
- Digits 1:0 show the latest code; digits 3:2 show the previous code.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range 2 to 2^20.
- BLANK_EMPTY, 1: 1 blanks a digit pair until that history slot has been filled; 0 shows 00 instead.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- keyPressed  in  8  scan code from the PS/2 receiver; stable whenever kpSignal is high.
- kpSignal  in  1  new-key strobe from the PS/2 receiver; asynchronous to clk; high for at least 3 clk cycles.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- dp  out  1  decimal point, active-low; held at 1 (off).
- newKey  out  1  one-cycle pulse when a code is captured.
- curCode  out  8  latest captured code.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - seg=7'h7F, an=4'hF, dp=1, newKey=0, curCode=0.
  - History registers cur and prev = 0; valid flags vCur and vPrev = 0.
  - Synchronizer flops = 0; divider = 0; digit index = 0.
  - Reset asserted mid-operation clears all of the above immediately.
- Synchronizer: 2-flop chain s1, s2 on kpSignal, plus a registered copy s3.
- Capture:
  - cap = s2 & ~s3, evaluated 2 cycles after kpSignal rises.
  - On cap: prev<=cur, vPrev<=vCur, cur<=keyPressed, vCur<=1, newKey=1 for exactly that cycle.
  - Latency from kpSignal rise to curCode update: 3 clk edges.
  - kpSignal held high causes exactly one capture; a new capture needs a falling then a rising edge.
  - A repeated identical code still shifts the history.
- Refresh:
  - Divider counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index (2 bits) increments 0→1→2→3→0.
- Digit nibble by index: 0 = cur[3:0], 1 = cur[7:4], 2 = prev[3:0], 3 = prev[7:4].
- Outputs, registered one cycle after the index changes:
  - an = ~(1<<idx).
  - seg = hex_to_seg7(nibble).
  - If BLANK_EMPTY=1 and the owning valid flag is 0: seg=7'h7F while an stays active.
- A capture mid-scan takes effect at the next segment-register update; no glitch requirement beyond that.
- Hex encoding (active-low gfedcba):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E

Decomposition:
- Shared package kbd_pkg:
  - SEG_BLANK=7'h7F and the 16-entry hex segment table as constants.
  - Default REFRESH_DIV.
  - A typedef for the 2-bit digit index.
- Sub-module hex_to_seg7: 4-bit in, 7-bit out, combinational, using the package table.
- Everything else stays in key_display_mux: synchronizer, capture/history, divider, scan, output registers.

Test Plan (sim with REFRESH_DIV=4):
- Reset, then run 40 cycles with no key -> an cycles E,D,B,7 every 4 cycles; seg=7F throughout; newKey never high.
- keyPressed=8'h1C, kpSignal pulsed high 5 cycles -> newKey high exactly 1 cycle, 3 edges after the rise; curCode=1C; digit 0 seg=46 (C), digit 1 seg=79 (1); digits 2,3 blank.
- Then keyPressed=8'h5A pulsed -> digits show 5A on 1:0 (seg 12, 08) and 1C on 3:2 (seg 46, 79).
- kpSignal held high 100 cycles with keyPressed changing mid-hold -> exactly one capture, using the value present at the capture cycle.
- BLANK_EMPTY=0 after reset -> all four digits seg=40 (0).
- Assert rst_n low mid-scan with both codes valid -> outputs go to seg=7F, an=F, curCode=0 without waiting for clk; after release the scan restarts at digit 0 with all digits blank.
